uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer placed directly downstream of the UART receiver.
- Takes each received byte from the receiver's parallel output, acknowledges it with a one-cycle read pulse, and stores it in a circular FIFO.
- Presents the bytes to the consumer (echo logic or CPU-side reader) as a first-word-fall-through queue with pop handshake, full/empty flags and an occupancy count.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries of 8 bits.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_D  input  8  byte from receiver (its D output); valid while RX_RXNE=1.
- RX_RXNE  input  1  receiver "byte pending" flag; held high until acknowledged.
- RX_RD  output  1  registered one-cycle acknowledge to the receiver's RD input.
- POP  input  1  consumer removes head entry; ignored when EMPTY=1.
- DOUT  output  8  head entry (FWFT); valid while EMPTY=0, holds last value otherwise.
- EMPTY  output  1  FIFO holds 0 entries.
- FULL  output  1  FIFO holds 2**DEPTH_LOG2 entries.
- COUNT  output  DEPTH_LOG2+1  current occupancy, 0..16.
- OVR  output  1  sticky overrun flag (see Optional Feature).
- OVR_CLR  input  1  clears OVR.

Behaviour:
- Reset (RST=1 at edge):
  - Pointers and COUNT = 0, EMPTY=1, FULL=0, RX_RD=0, OVR=0.
  - DOUT = 8'h00, capture FSM -> IDLE.
  - RST has priority over every other input.
  - Reset mid-handshake abandons the handshake; the receiver keeps RXNE high and the byte is captured again after reset.
- Capture FSM, 3 states:
  - IDLE: if RX_RXNE=1 and FULL=0 -> write RX_D at wr_ptr, wr_ptr+1, set RX_RD=1, go ACK.
  - IDLE with RX_RXNE=1 and FULL=1: default build stalls in IDLE (RX_RD stays 0, byte left pending in receiver).
  - ACK: RX_RD=1 for exactly this one cycle. The receiver clears RXNE at this edge. Drive RX_RD=0, go WAIT.
  - WAIT: stay until RX_RXNE=0, then go IDLE. Guarantees one byte is never written twice.
  - Capture-to-RX_RD latency: 1 clock. Minimum spacing between two captures: 3 clocks.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap 15 -> 0 naturally.
  - COUNT is separate, DEPTH_LOG2+1 bits.
  - FULL = (COUNT==16); EMPTY = (COUNT==0). Both derived from registered COUNT.
- Pop:
  - POP=1 and EMPTY=0 -> rd_ptr+1, COUNT-1.
  - DOUT shows the new head on the next cycle.
  - POP while EMPTY=1 -> no effect; COUNT never underflows.
- Simultaneous capture write and valid pop in the same cycle:
  - COUNT unchanged, both pointers advance.
  - When FULL, a same-cycle pop does not enable the write: the write is gated by registered FULL and occurs on a later cycle.
- DOUT is registered/read so that it equals mem[rd_ptr] whenever EMPTY=0, including the cycle right after the first write into an empty FIFO (1-cycle write-to-EMPTY-deassert latency).
- OVR_CLR=1 clears OVR. A set event in the same cycle wins over clear.

Optional Feature:
- Macro: UART_RX_FIFO_OVERRUN_EN.
- Defined:
  - In IDLE with RX_RXNE=1 and FULL=1, the FSM still acknowledges (RX_RD pulse, ACK/WAIT sequence), discards the byte and sets OVR=1.
  - FIFO contents and COUNT are unchanged.
  - The receiver never stalls.
- Not defined:
  - Full-FIFO stall behaviour as above.
  - OVR tied to 0; OVR_CLR ignored.

Test Plan:
- Reset then single byte: RX_D=8'hA5 with RX_RXNE=1, receiver model clears RXNE on RD -> exactly one RX_RD pulse, COUNT=1, EMPTY=0, DOUT=8'hA5; POP -> EMPTY=1, COUNT=0.
- Ordering and wrap: push 8'h00..8'h13 (20 bytes), popping after each 4 -> bytes out in order 8'h00..8'h13, pointers wrap past 15, COUNT never exceeds 16.
- Full stall (macro off): push 17 bytes with no pops -> FULL=1 after 16th, 17th byte not acknowledged (RX_RXNE stays 1); one POP -> 17th byte captured, COUNT=16 again, OVR=0.
- Overrun (macro on): same stimulus -> 17th byte acknowledged, OVR=1, COUNT=16, head still 8'h00; OVR_CLR pulse -> OVR=0.
- Simultaneous: COUNT=5, capture 8'h3C in same cycle as POP -> COUNT stays 5, 8'h3C emerges as 5th subsequent pop; POP on empty FIFO -> COUNT stays 0.
- Reset mid-operation: assert RST during ACK with COUNT=7 -> COUNT=0, EMPTY=1, RX_RD=0 next cycle; pending byte captured once after RST released.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16-entry FWFT receive buffer behind a UART receiver.
// Optional overrun-discard mode: define UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_D,
  input  logic                  RX_RXNE,
  output logic                  RX_RD,
  input  logic                  POP,
  output logic [7:0]            DOUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVR,
  input  logic                  OVR_CLR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_CNT_ONE =
    (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE =
    DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_nxt;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [7:0]            r_dout;
  logic [7:0]            w_head;
  logic                  r_rx_rd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_take;
  logic                  w_wr;
  logic                  w_pop;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = POP && !w_empty;

`ifdef UART_RX_FIFO_OVERRUN_EN
  // a full FIFO still acknowledges; the byte is dropped
  assign w_accept = 1'b1;
`else
  // a full FIFO leaves the byte pending in the receiver
  assign w_accept = !w_full;
`endif

  // capture FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // capture FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (RX_RXNE && w_accept) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_WAIT;
      S_WAIT:  if (!RX_RXNE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // capture FSM outputs: take the byte, and write it unless full
  always_comb begin
    w_take = 1'b0;
    w_wr   = 1'b0;
    if (r_state == S_IDLE) begin
      w_take = RX_RXNE && w_accept;
      w_wr   = RX_RXNE && !w_full;
    end
  end

  // one-cycle acknowledge, raised on the edge that captures
  always_ff @(posedge CLK) begin
    if (RST) r_rx_rd <= 1'b0;
    else     r_rx_rd <= w_take;
  end

  // storage array; contents need no reset
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= RX_D;
  end

  // occupancy after this cycle's write and pop
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  // next head; bypass the incoming byte when it lands at the head
  always_comb begin
    w_rd_nxt = w_pop ? (r_rd_ptr + C_PTR_ONE) : r_rd_ptr;
    w_head   = r_mem[w_rd_nxt];
    if (w_wr && (r_wr_ptr == w_rd_nxt)) w_head = RX_D;
  end

  // registered head; holds the last value while empty
  always_ff @(posedge CLK) begin
    if (RST)                    r_dout <= 8'h00;
    else if (w_count_nxt != '0) r_dout <= w_head;
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic r_ovr;
  logic w_ovr_set;

  assign w_ovr_set = w_take && w_full;

  // sticky overrun flag; a set beats a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RST)            r_ovr <= 1'b0;
    else if (w_ovr_set) r_ovr <= 1'b1;
    else if (OVR_CLR)   r_ovr <= 1'b0;
  end

  assign OVR = r_ovr;
`else
  logic w_unused;

  assign w_unused = OVR_CLR;
  assign OVR      = 1'b0;
`endif

  assign RX_RD = r_rx_rd;
  assign DOUT  = r_dout;
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign COUNT = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench with a pop scoreboard.
// Honours UART_RX_FIFO_OVERRUN_EN like the design.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_D;
  logic       RX_RXNE;
  logic       RX_RD;
  logic       POP;
  logic [7:0] DOUT;
  logic       EMPTY;
  logic       FULL;
  logic [4:0] COUNT;
  logic       OVR;
  logic       OVR_CLR;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int p0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RX_D    (RX_D),
    .RX_RXNE (RX_RXNE),
    .RX_RD   (RX_RD),
    .POP     (POP),
    .DOUT    (DOUT),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .COUNT   (COUNT),
    .OVR     (OVR),
    .OVR_CLR (OVR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_pop();
    POP = 1'b1;
    tick();
    POP = 1'b0;
  endtask

  // receiver model: present byte, clear RXNE on the RD edge
  task automatic send_byte(input logic [7:0] b, input bit cap);
    bit acked;
    acked = 1'b0;
    if (cap) exp_q.push_back(b);
    RX_D = b;
    RX_RXNE = 1'b1;
    for (int i = 0; i < 60 && !acked; i++) begin
      @(negedge CLK);
      if (RX_RD === 1'b1) acked = 1'b1;
    end
    chk("ack", {31'd0, acked}, 32'd1);
    if (acked) @(posedge CLK);
    #1;
    RX_RXNE = 1'b0;
    tick();
  endtask

  // count acknowledge cycles
  always @(negedge CLK) begin
    if (RX_RD === 1'b1) pulses++;
  end

  // scoreboard monitor: compare head on every accepted pop
  always @(negedge CLK) begin
    if (RST === 1'b0 && POP === 1'b1 && EMPTY === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, expected none", DOUT);
      end else begin
        chk("pop_data", {24'd0, DOUT}, {24'd0, exp_q.pop_front()});
      end
    end
    if (RST === 1'b0) chk("count_le_16", {31'd0, COUNT <= 5'd16}, 32'd1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    RX_D = 8'h00;
    RX_RXNE = 1'b0;
    POP = 1'b0;
    OVR_CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_rx_rd", RX_RD, 0);
    chk("rst_ovr", OVR, 0);
    chk("rst_dout", DOUT, 8'h00);

    // single byte
    p0 = pulses;
    send_byte(8'hA5, 1'b1);
    chk("single_pulses", pulses - p0, 1);
    chk("single_count", COUNT, 1);
    chk("single_empty", EMPTY, 0);
    chk("single_dout", DOUT, 8'hA5);
    do_pop();
    chk("single_pop_empty", EMPTY, 1);
    chk("single_pop_count", COUNT, 0);

    // ordering and pointer wrap
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i), 1'b1);
      if (i % 4 == 3) do_pop();
    end
    chk("wrap_count", COUNT, 15);
    for (int i = 0; i < 15; i++) do_pop();
    chk("wrap_empty", EMPTY, 1);

    // fill to 16
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    chk("fill_full", FULL, 1);
    chk("fill_count", COUNT, 16);
    chk("fill_head", DOUT, 8'h00);
    p0 = pulses;
`ifdef UART_RX_FIFO_OVERRUN_EN
    send_byte(8'h10, 1'b0);
    chk("ovr_pulses", pulses - p0, 1);
    chk("ovr_set", OVR, 1);
    chk("ovr_count", COUNT, 16);
    chk("ovr_head", DOUT, 8'h00);
    OVR_CLR = 1'b1;
    tick();
    OVR_CLR = 1'b0;
    chk("ovr_clr", OVR, 0);
    fork
      send_byte(8'h11, 1'b0);
      begin
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
      end
    join
    chk("ovr_set_wins", OVR, 1);
    chk("ovr_count2", COUNT, 16);
    OVR_CLR = 1'b1;
    tick();
    OVR_CLR = 1'b0;
    chk("ovr_clr2", OVR, 0);
    for (int i = 0; i < 16; i++) do_pop();
`else
    fork
      send_byte(8'h10, 1'b1);
      begin
        repeat (10) tick();
        chk("stall_no_ack", pulses - p0, 0);
        chk("stall_full", FULL, 1);
        do_pop();
      end
    join
    chk("stall_count", COUNT, 16);
    chk("stall_ovr", OVR, 0);
    OVR_CLR = 1'b1;
    tick();
    OVR_CLR = 1'b0;
    chk("stall_ovr_clr", OVR, 0);
    for (int i = 0; i < 16; i++) do_pop();
`endif
    chk("full_drain_empty", EMPTY, 1);

    // simultaneous capture and pop
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b1);
    chk("sim_count_pre", COUNT, 5);
    fork
      send_byte(8'h3C, 1'b1);
      do_pop();
    join
    chk("sim_count", COUNT, 5);
    for (int i = 0; i < 5; i++) do_pop();
    chk("sim_empty", EMPTY, 1);
    do_pop();
    chk("pop_empty_count", COUNT, 0);
    chk("pop_empty_flag", EMPTY, 1);

    // reset during acknowledge
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 1'b1);
    chk("rst_mid_pre", COUNT, 7);
    RX_D = 8'h77;
    RX_RXNE = 1'b1;
    p0 = 0;
    for (int i = 0; i < 10 && p0 == 0; i++) begin
      @(negedge CLK);
      if (RX_RD === 1'b1) p0 = 1;
    end
    chk("rst_mid_ack_seen", p0, 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_q.delete();
    RST = 1'b0;
    chk("rst_mid_count", COUNT, 0);
    chk("rst_mid_empty", EMPTY, 1);
    chk("rst_mid_rx_rd", RX_RD, 0);
    p0 = pulses;
    send_byte(8'h77, 1'b1);
    chk("rst_mid_recapture", pulses - p0, 1);
    chk("rst_mid_count1", COUNT, 1);
    chk("rst_mid_dout", DOUT, 8'h77);
    do_pop();
    chk("rst_mid_empty2", EMPTY, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
